hex_display_scanner: RTL and testbench



---
 rtl/hex_display_scanner.sv | 67 ++++++
 tb/tb_hex_display_scanner.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: holds a hex word and scans it nibble by nibble onto a 7-segment decoder
module hex_display_scanner #(
   parameter int DIGITS   = 8,
   parameter int DWELL    = 50000,
   parameter int GAP      = 2,
   parameter bit LZ_BLANK = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_data,
   output logic [3:0]            digit_nibble,
   output logic [DIGITS-1:0]     digit_sel,
   output logic                  blank,
   output logic                  frame_done
);
   localparam int CW = $clog2(DWELL > GAP ? DWELL : GAP) + 1;
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   typedef enum logic {S_SCAN, S_GAP} state_t;
   state_t              state;
   logic [IW-1:0]       idx;
   logic [CW-1:0]       cnt;
   logic [4*DIGITS-1:0] shown;
   logic [4*DIGITS-1:0] pending;
   logic                pending_full;
   logic [DIGITS-1:0]   hi_zero;
   logic                lit;
   logic                last_cnt;
   // hi_zero[i] is set when digit i and every digit above it are zero
   always_comb begin
      hi_zero = '0;
      for (int i = 0; i < DIGITS; i++) hi_zero[i] = (shown >> (4*i)) == '0;
   end
   assign lit        = state == S_SCAN && !(LZ_BLANK && idx != '0 && hi_zero[idx]);
   assign last_cnt   = cnt == CW'(state == S_SCAN ? DWELL - 1 : GAP - 1);
   assign frame_done = state == S_GAP && last_cnt && idx == IW'(DIGITS - 1);
   assign in_ready   = !pending_full;
   // slot sequencer, registered display outputs and the one-entry word buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_SCAN;
         idx          <= '0;
         cnt          <= '0;
         shown        <= '0;
         pending      <= '0;
         pending_full <= 1'b0;
         digit_sel    <= '1;
         digit_nibble <= '0;
         blank        <= 1'b1;
      end else begin
         digit_sel <= lit ? ~(DIGITS'(1) << idx) : '1;
         blank     <= !lit;
         if (state == S_SCAN) digit_nibble <= shown[4*idx +: 4];
         cnt <= last_cnt ? '0 : cnt + 1'b1;
         if (last_cnt) state <= state == S_SCAN ? S_GAP : S_SCAN;
         if (last_cnt && state == S_GAP) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
         if (in_valid && !pending_full) begin
            pending      <= in_data;
            pending_full <= 1'b1;
         end else if (frame_done && pending_full) begin
            shown        <= pending;
            pending_full <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_hex_display_scanner.sv
// tb_hex_display_scanner: directed and random checks of two scanners (blanking on/off) against a slot-arithmetic model
module tb_hex_display_scanner;
   localparam int D = 4, DW = 4, G = 2, S = DW + G, F = D * S;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [15:0]   in_data = '0;
   logic          rdy_a, rdy_b, blank_a, blank_b, fd_a, fd_b;
   logic [3:0]    nib_a, nib_b, sel_a, sel_b;
   int            checks = 0;
   int            passes = 0;
   int            k;
   logic [15:0]   m_shown, m_pend;
   bit            m_full;
   logic [3:0]    m_nib, exp_sel_a, exp_sel_b;
   bit            exp_blank_a, exp_blank_b, exp_fd;

   hex_display_scanner #(.DIGITS(D), .DWELL(DW), .GAP(G), .LZ_BLANK(1)) u_lz (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
      .digit_nibble(nib_a), .digit_sel(sel_a), .blank(blank_a), .frame_done(fd_a));
   hex_display_scanner #(.DIGITS(D), .DWELL(DW), .GAP(G), .LZ_BLANK(0)) u_nolz (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
      .digit_nibble(nib_b), .digit_sel(sel_b), .blank(blank_b), .frame_done(fd_b));

   always #5 clk = ~clk;

   task automatic model_reset();
      k = 0; m_shown = '0; m_pend = '0; m_full = 0; m_nib = '0;
      exp_sel_a = 4'hF; exp_sel_b = 4'hF; exp_blank_a = 1; exp_blank_b = 1; exp_fd = 0;
   endtask

   // one clock edge: position k within the frame decides slot and lit/gap phase
   task automatic model_edge();
      int p, slot;
      bit scan, bl;
      logic [3:0] one_hot_low;
      p = k % F;
      slot = p / S;
      scan = (p % S) < DW;
      one_hot_low = ~(4'b0001 << slot);
      if (scan) m_nib = m_shown[4*slot +: 4];
      bl = slot != 0 && (m_shown >> (4*slot)) == 16'h0;
      exp_sel_a = (scan && !bl) ? one_hot_low : 4'hF;
      exp_blank_a = !(scan && !bl);
      exp_sel_b = scan ? one_hot_low : 4'hF;
      exp_blank_b = !scan;
      if (in_valid && !m_full) begin
         m_pend = in_data;
         m_full = 1;
      end else if (p == F - 1 && m_full) begin
         m_shown = m_pend;
         m_full = 0;
      end
      k++;
      exp_fd = (k % F) == F - 1;
   endtask

   task automatic check(input string tag);
      logic [10:0] oa, ea, ob, eb;
      oa = {sel_a, blank_a, nib_a, fd_a, rdy_a};
      ea = {exp_sel_a, exp_blank_a, m_nib, exp_fd, !m_full};
      ob = {sel_b, blank_b, nib_b, fd_b, rdy_b};
      eb = {exp_sel_b, exp_blank_b, m_nib, exp_fd, !m_full};
      checks++;
      assert (oa === ea) passes++; else $error("FAIL %s lz1 {sel,blank,nib,fd,rdy}: got %h expected %h (k=%0d)", tag, oa, ea, k);
      checks++;
      assert (ob === eb) passes++; else $error("FAIL %s lz0 {sel,blank,nib,fd,rdy}: got %h expected %h (k=%0d)", tag, ob, eb, k);
   endtask

   task automatic check1(input string tag, input logic [15:0] got, input logic [15:0] want);
      checks++;
      assert (got === want) passes++; else $error("FAIL %s: got %h expected %h", tag, got, want);
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      if (rst_n) model_edge();
      #1 check(tag);
      @(negedge clk);
   endtask

   task automatic offer(input logic [15:0] w, input string tag);
      in_valid = 1; in_data = w;
      tick(tag);
      in_valid = 0;
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   task automatic wait_shown(input logic [15:0] w, input string tag);
      int n = 0;
      while (m_shown !== w && n < 4 * F) begin tick(tag); n++; end
      check1({tag, "_reached"}, m_shown, w);
   endtask

   task automatic align_frame(input string tag);
      while (k % F != 0) tick(tag);
   endtask

   initial begin
      logic [15:0] seq;
      logic [3:0]  q[$];
      int          pulses, n;
      bit          hit;
      model_reset();
      in_valid = 1; in_data = 16'($urandom);
      @(negedge clk);
      #0 check("reset_hold");
      for (int i = 0; i < 3; i++) begin in_data = 16'($urandom); tick("reset_hold"); end
      in_valid = 0;
      rst_n = 1;
      run(F, "zero_word");

      offer(16'h1A3F, "load_1a3f");
      wait_shown(16'h1A3F, "wait_1a3f");
      align_frame("align_1a3f");
      q.delete();
      pulses = 0;
      for (int i = 0; i < 2 * F; i++) begin
         tick("scan_1a3f");
         if ((k - 1) % S == 0 && i < F) q.push_back(nib_b);
         if (fd_b) pulses++;
      end
      seq = {q[3], q[2], q[1], q[0]};
      check1("nibble_order", seq, 16'h1A3F);
      check1("frame_pulses", 16'(pulses), 16'd2);

      offer(16'h0050, "load_0050");
      wait_shown(16'h0050, "wait_0050");
      run(F, "lz_0050");
      offer(16'h0000, "load_0000");
      wait_shown(16'h0000, "wait_0000");
      run(F, "lz_0000");

      align_frame("align_bp");
      run(7, "bp_mid");
      offer(16'h1111, "bp_1111");
      in_valid = 1; in_data = 16'h2222;
      check1("bp_ready_low", {15'b0, rdy_a}, 16'h0);
      n = 0;
      while (!(m_full && m_pend == 16'h2222) && n < 4 * F) begin tick("bp_stall"); n++; end
      check1("bp_2222_accepted", m_pend, 16'h2222);
      check1("bp_shown_1111", m_shown, 16'h1111);
      in_valid = 0;
      wait_shown(16'h2222, "wait_2222");
      run(F, "show_2222");

      n = 0;
      while (!(exp_fd && !m_full) && n < 2 * F) begin tick("coin_seek"); n++; end
      check1("coin_at_boundary", {15'b0, fd_a}, 16'h1);
      offer(16'h00AB, "coin_xfer");
      check1("coin_old_word", m_shown, 16'h2222);
      run(F - 1, "coin_old_frame");
      wait_shown(16'h00AB, "wait_00ab");
      run(F, "show_00ab");

      for (int i = 0; i < 8 * F; i++) begin
         in_valid = $urandom_range(0, 3) == 0;
         in_data = 16'($urandom) >> (4 * $urandom_range(0, 4));
         tick("random");
      end
      in_valid = 0;

      align_frame("align_rst");
      offer(16'($urandom) | 16'h8000, "rst_load");
      hit = 0;
      n = 0;
      while (!hit && n < 4 * F) begin
         tick("rst_seek");
         hit = m_full && (k - 1) % F == 2 * S + 1;
         n++;
      end
      check1("rst_seek_hit", {15'b0, hit}, 16'h1);
      #2 rst_n = 0;
      #1 model_reset();
      check("rst_async");
      tick("rst_held");
      rst_n = 1;
      check1("rst_ready_after", {15'b0, rdy_a}, 16'h1);
      run(2 * F, "after_rst");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
